// File: rtl/exec_controller.sv
// Multi-cycle sequencer for the BitBlaster datapath: captures an instruction
// on exec and walks it through timesteps T1-T3, driving bus and load enables.
module exec_controller #(
  parameter int IR_W = 10,
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exec,
  input  logic [IR_W-1:0] instr,
  output logic            ir_load,
  output logic            ext_out,
  output logic [NREG-1:0] rout,
  output logic [NREG-1:0] rin,
  output logic            a_load,
  output logic            g_load,
  output logic            g_out,
  output logic [3:0]      alu_op,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  logic [1:0]      state_reg, state_next;
  logic [IR_W-1:0] ir_reg;
  logic [3:0]      opcode;
  logic [1:0]      rx, ry;
  logic [NREG-1:0] rx_oh, ry_oh;
  logic            is_load, is_copy, is_bin, is_un;
  logic            unused_ir_bits;

  assign opcode = ir_reg[9:6];
  assign rx     = ir_reg[5:4];
  assign ry     = ir_reg[3:2];
  assign unused_ir_bits = ^ir_reg[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg_sel
      assign rx_oh[gi] = (rx == 2'(gi));
      assign ry_oh[gi] = (ry == 2'(gi));
    end
  endgenerate

  always_comb begin
    is_load = (opcode == 4'b0000);
    is_copy = (opcode == 4'b0001);
    is_bin  = (opcode == 4'b0010) || (opcode == 4'b0011) || (opcode == 4'b0110) ||
              (opcode == 4'b0111) || (opcode == 4'b1000);
    is_un   = (opcode == 4'b0100) || (opcode == 4'b0101);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= T0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (ir_load) ir_reg <= instr;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_load    = 1'b0;
    ext_out    = 1'b0;
    rout       = '0;
    rin        = '0;
    a_load     = 1'b0;
    g_load     = 1'b0;
    g_out      = 1'b0;
    alu_op     = 4'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      T0: begin
        // Gate with reset so a held exec cannot strobe the IR during reset.
        ir_load = exec & reset;
        if (exec) state_next = T1;
      end
      T1: begin
        busy = 1'b1;
        if (is_load) begin
          ext_out    = 1'b1;
          rin        = rx_oh;
          done       = 1'b1;
          state_next = T0;
        end else if (is_copy) begin
          rout       = ry_oh;
          rin        = rx_oh;
          done       = 1'b1;
          state_next = T0;
        end else if (is_bin || is_un) begin
          rout       = rx_oh;
          a_load     = 1'b1;
          state_next = T2;
        end else begin
          done       = 1'b1;
          state_next = T0;
        end
      end
      T2: begin
        busy   = 1'b1;
        g_load = 1'b1;
        alu_op = opcode;
        // Unary ops take their only operand from A, so the bus stays idle.
        if (is_bin) rout = ry_oh;
        state_next = T3;
      end
      default: begin
        busy       = 1'b1;
        g_out      = 1'b1;
        rin        = rx_oh;
        done       = 1'b1;
        state_next = T0;
      end
    endcase
  end

endmodule

// File: tb/tb_exec_controller.sv
// Randomized bench for exec_controller: each accepted instruction expands into
// a list of expected per-cycle output vectors that is replayed against the DUT.
module tb_exec_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       exec;
  logic [9:0] instr;
  logic       ir_load, ext_out, a_load, g_load, g_out, busy, done;
  logic [3:0] rout, rin, alu_op;

  // {ir_load, ext_out, rout, rin, a_load, g_load, g_out, alu_op, busy, done}
  typedef logic [18:0] vec_t;

  vec_t dut_vec;
  vec_t model_q[$];
  int   n_checks = 0;
  int   n_passed = 0;

  exec_controller #(.IR_W(10), .NREG(4)) dut (
    .clk(clk), .reset(reset), .exec(exec), .instr(instr),
    .ir_load(ir_load), .ext_out(ext_out), .rout(rout), .rin(rin),
    .a_load(a_load), .g_load(g_load), .g_out(g_out), .alu_op(alu_op),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign dut_vec = {ir_load, ext_out, rout, rin, a_load, g_load, g_out, alu_op, busy, done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [3:0] oh(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic vec_t mk(input logic ext, input logic [3:0] ro, input logic [3:0] ri,
                              input logic al, input logic gl, input logic go,
                              input logic [3:0] op, input logic dn);
    return {1'b0, ext, ro, ri, al, gl, go, op, 1'b1, dn};
  endfunction

  // Micro-program for one instruction: one entry per cycle after acceptance.
  task automatic push_program(input logic [9:0] ins);
    logic [3:0] op;
    logic [1:0] rx, ry;
    op = ins[9:6];
    rx = ins[5:4];
    ry = ins[3:2];
    case (op)
      4'd0: model_q.push_back(mk(1, 0, oh(rx), 0, 0, 0, 0, 1));
      4'd1: model_q.push_back(mk(0, oh(ry), oh(rx), 0, 0, 0, 0, 1));
      4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd4, 4'd5: begin
        model_q.push_back(mk(0, oh(rx), 0, 1, 0, 0, 0, 0));
        model_q.push_back(mk(0, (op == 4'd4 || op == 4'd5) ? 4'd0 : oh(ry), 0, 0, 1, 0, op, 0));
        model_q.push_back(mk(0, 0, oh(rx), 0, 0, 1, 0, 1));
      end
      default: model_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic check_invariants();
    check("bus_drivers_le1", 32'(((32'(ext_out) + 32'(g_out) + $countones(rout)) <= 1)), 32'd1);
    check("rin_onehot0", 32'($onehot0(rin)), 32'd1);
    check("rout_onehot0", 32'($onehot0(rout)), 32'd1);
  endtask

  // Called at posedge+1: drive, compare at the falling edge, advance model.
  task automatic step(input logic e, input logic [9:0] ins);
    vec_t exp_v;
    exec  = e;
    instr = ins;
    #4;
    exp_v = (model_q.size() == 0) ? {e, 18'd0} : model_q[0];
    check("outputs", 32'(dut_vec), 32'(exp_v));
    check_invariants();
    @(posedge clk);
    if (model_q.size() != 0) begin
      void'(model_q.pop_front());
    end else if (e) begin
      push_program(ins);
      $display("accept instr=%b_%b_%b_%b at %0t", ins[9:6], ins[5:4], ins[3:2], ins[1:0], $time);
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    exec  = 1'b1;
    instr = 10'b0000_10_00_00;
    @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) step(1'b0, 10'($urandom));

    // LOAD R2, COPY R1<-R3, ADD R0,R1
    step(1'b1, 10'b0000_10_00_00); step(1'b0, 10'd0); step(1'b0, 10'd0);
    step(1'b1, 10'b0001_01_11_00); step(1'b0, 10'd0); step(1'b0, 10'd0);
    step(1'b1, 10'b0010_00_01_00);
    for (int i = 0; i < 4; i++) step(1'b0, 10'($urandom));

    // INV R3 with exec held high: second accept lands in the T0 after done
    for (int i = 0; i < 7; i++) step(1'b1, (i == 0) ? 10'b0100_11_00_00 : 10'b1111_00_00_00);

    // Reset asserted during T2 of ADD
    step(1'b0, 10'd0); step(1'b0, 10'd0);
    step(1'b1, 10'b0010_00_01_00);
    step(1'b0, 10'd0);
    exec = 1'b0;
    #4;
    check("add_t2", 32'(dut_vec), 32'(model_q[0]));
    #1;
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", 32'(dut_vec), 32'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, 10'd0);
    check("busy_after_reset", 32'(busy), 32'd0);

    // Randomized traffic; instr is scrambled every cycle to prove only IR matters
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), 10'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 10'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
